mul_seq_ctrl: RTL and testbench

Sequential controller for the CPU's signed 32×32 multiply. It latches operands on a start handshake and retires one radix-4 Booth bit-pair per clock over 16 iterations, sharing a single 64-bit add/subtract path. It then presents the 64-bit product for the HI/LO registers with a one-cycle done pulse. It sits between the control unit (MUL instruction issue) and the HI/LO register pair, replacing a purely combinational multiplier to shorten the critical path.

---
 rtl/mul_seq_ctrl_if.sv | 20 ++
 rtl/mul_seq_ctrl.sv | 118 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Multiply request/result bundle between the control unit and the sequential multiplier.
interface mul_seq_ctrl_if;
  logic        start;
  logic        flush;
  logic [31:0] Q;
  logic [31:0] M;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, flush, Q, M,
    input  busy, done, product
  );

  modport slave (
    input  start, flush, Q, M,
    output busy, done, product
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequential signed 32x32 multiplier: radix-4 Booth, one bit-pair per clock, 16 iterations.
module mul_seq_ctrl (
  input  logic          clock,
  input  logic          clear_n,
  mul_seq_ctrl_if.slave bus
);

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    k, k_nxt;
  logic [OP_W-1:0]     qr, qr_nxt;
  logic [PROD_W-1:0]   mr, mr_nxt;
  logic [PROD_W-1:0]   acc, acc_nxt;
  logic [PROD_W-1:0]   product_q, product_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;

  logic [OP_W:0]       qr_ext;
  logic [5:0]          shamt;
  logic [2:0]          triplet;
  logic [PROD_W-1:0]   m_sh;
  logic [PROD_W-1:0]   m_sh2;
  logic [PROD_W-1:0]   term;
  logic [PROD_W-1:0]   sum;

  // Booth digit selection for the current bit-pair; Qr[-1] is the appended zero.
  always_comb begin
    qr_ext  = {qr, 1'b0};
    shamt   = {1'b0, k, 1'b0};
    triplet = qr_ext[shamt +: 3];
    m_sh    = mr << shamt;
    m_sh2   = mr << (shamt + 6'd1);
    term    = '0;
    case (triplet)
      3'b001, 3'b010: term = m_sh;
      3'b011:         term = m_sh2;
      3'b100:         term = PROD_W'(-m_sh2);
      3'b101, 3'b110: term = PROD_W'(-m_sh);
      default:        term = '0;
    endcase
    sum = acc + term;
  end

  // Next-state and datapath update; flush overrides everything except reset.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    qr_nxt      = qr;
    mr_nxt      = mr;
    acc_nxt     = acc;
    product_nxt = product_q;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          qr_nxt    = bus.Q;
          mr_nxt    = {{(PROD_W-OP_W){bus.M[OP_W-1]}}, bus.M};
          acc_nxt   = '0;
          k_nxt     = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else begin
          acc_nxt = sum;
          if (k == CNT_W'(15)) begin
            product_nxt = sum;
            state_nxt   = DONE;
          end else begin
            k_nxt = k + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      k         <= '0;
      qr        <= '0;
      mr        <= '0;
      acc       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      qr        <= qr_nxt;
      mr        <= mr_nxt;
      acc       <= acc_nxt;
      product_q <= product_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl against a plain-arithmetic signed multiply model.
module tb_mul_seq_ctrl;

  logic clock = 1'b0;
  logic clear_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] ref_product;

  always #5 clock = ~clock;

  mul_seq_ctrl_if bus ();

  mul_seq_ctrl dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Present a start for one edge and confirm the unit went busy.
  task automatic accept(input logic [31:0] q, input logic [31:0] m);
    @(negedge clock);
    bus.Q     = q;
    bus.M     = m;
    bus.start = 1'b1;
    bus.flush = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    check("no_done_after_accept", 64'(bus.done), 64'd0);
  endtask

  // One complete multiply; noisy mode scrambles Q/M/start while the unit is running.
  task automatic run_mul(input logic [31:0] q, input logic [31:0] m, input bit noisy);
    int lat;
    int busy_cnt;
    bit seen;
    accept(q, m);
    lat      = 0;
    busy_cnt = 1;
    seen     = 1'b0;
    while (!seen && lat < 40) begin
      if (noisy) begin
        bus.Q     = $urandom;
        bus.M     = $urandom;
        bus.start = 1'($urandom_range(0, 1));
      end
      @(posedge clock);
      #1;
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
      if (lat == 8) check("product_hold_run", bus.product, ref_product);
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'd16);
    ref_product = ref_mul(q, m);
    check("product", bus.product, ref_product);
    check("busy_cycles", 64'(busy_cnt), 64'd17);
    @(posedge clock);
    #1;
    check("done_pulse_end", 64'(bus.done), 64'd0);
    check("busy_end", 64'(bus.busy), 64'd0);
    check("product_kept", bus.product, ref_product);
  endtask

  initial begin
    int dones;
    int cyc;

    clear_n   = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.Q     = '0;
    bus.M     = '0;
    ref_product = '0;
    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;

    // Directed vectors.
    run_mul(32'd3, 32'd5, 1'b0);
    check("spec_3x5", bus.product, 64'h0000_0000_0000_000F);
    run_mul(32'hFFFF_FFF9, 32'd6, 1'b0);
    check("spec_m7x6", bus.product, 64'hFFFF_FFFF_FFFF_FFD6);
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b0);
    check("spec_min_min", bus.product, 64'h4000_0000_0000_0000);
    run_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    check("spec_max_min", bus.product, 64'hC000_0000_8000_0000);

    // Start held high, operands changed during the run.
    @(negedge clock);
    bus.Q     = 32'd3;
    bus.M     = 32'd5;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.Q = 32'd9;
    bus.M = 32'd9;
    dones = 0;
    cyc   = 0;
    while (dones < 2 && cyc < 80) begin
      @(posedge clock);
      #1;
      cyc++;
      if (bus.done) begin
        dones++;
        if (dones == 1) check("held_first", bus.product, 64'd15);
        else begin
          check("held_second", bus.product, 64'd81);
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("held_done_count", 64'(dones), 64'd2);
    ref_product = 64'd81;
    repeat (2) @(posedge clock);
    #1;

    // Flush mid-run leaves the previous product and gives no done.
    run_mul(32'd3, 32'd5, 1'b0);
    accept(32'd2, 32'd2);
    repeat (8) begin
      @(posedge clock);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_done", 64'(bus.done), 64'd0);
    check("flush_product", bus.product, 64'd15);
    dones = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (bus.done) dones++;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    run_mul(32'd2, 32'd2, 1'b0);
    check("after_flush_2x2", bus.product, 64'd4);

    // Flush and start together in IDLE: start dropped.
    @(negedge clock);
    bus.Q     = 32'd11;
    bus.M     = 32'd11;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("idle_flush_wins", 64'(bus.busy), 64'd0);
    @(posedge clock);
    #1;

    // Random operands with noise on the inputs while running.
    for (int i = 0; i < 20; i++) begin
      run_mul($urandom, $urandom, 1'b1);
    end

    // Asynchronous clear in the middle of a run.
    accept(32'd7, 32'd9);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    #2;
    clear_n = 1'b0;
    #1;
    check("clear_busy", 64'(bus.busy), 64'd0);
    check("clear_done", 64'(bus.done), 64'd0);
    check("clear_product", bus.product, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    ref_product = '0;
    run_mul(32'd4, 32'hFFFF_FFFC, 1'b0);
    check("after_clear_4xm4", bus.product, 64'hFFFF_FFFF_FFFF_FFF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
